// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - DMA register map, bus park values and issuer state encoding
package dma_pkg;

    localparam logic [15:0] REG_START   = 16'h0100;
    localparam logic [15:0] REG_SRCL    = 16'h0101;
    localparam logic [15:0] REG_SRCM    = 16'h0102;
    localparam logic [15:0] REG_DSTL    = 16'h0103;
    localparam logic [15:0] REG_DSTM    = 16'h0104;
    localparam logic [15:0] REG_NUM     = 16'h0105;
    localparam logic [7:0]  START_MAGIC = 8'hFF;
    localparam logic [15:0] PARK_ADDR   = 16'h0000;
    localparam logic [7:0]  PARK_DATA   = 8'h00;
    localparam logic [2:0]  DEFAULT_G   = 3'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_SRCL,
        ST_W_SRCM,
        ST_W_DSTL,
        ST_W_DSTM,
        ST_W_NUM,
        ST_W_START,
        ST_WAIT_IRQ,
        ST_ACK
    } issuer_state_e;

    // NUM_TRANSFER holds block count minus one; the DMA scales blocks by 2**g.
    function automatic logic [15:0] xfer_bytes(input logic [7:0] nblk, input logic [2:0] g);
        return ({8'h00, nblk} + 16'd1) << g;
    endfunction

endpackage

// File: rtl/dma_issuer_timer.sv
// rtl/dma_issuer_timer.sv - 16-bit saturating cycle counter with terminal-count compare
module dma_issuer_timer #(
    parameter logic [15:0] LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] count_o,
    output logic        tc_o
);

    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= 16'h0000;
        end else if (en_i && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == LIMIT);

endmodule

// File: rtl/dma_cmd_issuer.sv
// rtl/dma_cmd_issuer.sv - programs the DMA for one command, waits for irq, acks and reports
// Optional irq wait limit enabled by defining DMA_ISSUER_TIMEOUT_EN.
module dma_cmd_issuer
    import dma_pkg::*;
#(
    parameter logic [2:0]  G       = DEFAULT_G,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_src,
    input  logic [15:0] cmd_dst,
    input  logic [7:0]  cmd_nblk,
    output logic [15:0] auxdaddr,
    output logic [7:0]  auxdin,
    input  logic        irq,
    output logic        ack,
    output logic        done,
    output logic [15:0] done_bytes,
    output logic [15:0] done_cycles,
    output logic        timeout_err
);

    issuer_state_e state_q, state_d;
    logic [15:0]   src_q, src_d;
    logic [15:0]   dst_q, dst_d;
    logic [7:0]    nblk_q, nblk_d;
    logic [15:0]   done_bytes_q, done_bytes_d;
    logic [15:0]   done_cycles_q, done_cycles_d;
    logic          err_q, err_d;

    logic          timer_clr, timer_en, timer_tc, timeout_hit;
    logic [15:0]   timer_count;

    // Counter is cleared in IDLE and starts in W_START so it reads 1 in the first WAIT_IRQ cycle.
    dma_issuer_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .count_o (timer_count),
        .tc_o    (timer_tc)
    );

`ifdef DMA_ISSUER_TIMEOUT_EN
    assign timeout_hit = timer_tc;
`else
    logic unused_tc;
    assign unused_tc   = timer_tc;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            src_q         <= 16'h0000;
            dst_q         <= 16'h0000;
            nblk_q        <= 8'h00;
            done_bytes_q  <= 16'h0000;
            done_cycles_q <= 16'h0000;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            nblk_q        <= nblk_d;
            done_bytes_q  <= done_bytes_d;
            done_cycles_q <= done_cycles_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        nblk_d        = nblk_q;
        done_bytes_d  = done_bytes_q;
        done_cycles_d = done_cycles_q;
        err_d         = err_q;
        cmd_ready     = 1'b0;
        auxdaddr      = PARK_ADDR;
        auxdin        = PARK_DATA;
        ack           = 1'b0;
        done          = 1'b0;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                timer_clr = 1'b1;
                if (cmd_valid) begin
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    nblk_d  = cmd_nblk;
                    err_d   = 1'b0;
                    state_d = ST_W_SRCL;
                end
            end
            ST_W_SRCL: begin
                auxdaddr = REG_SRCL;
                auxdin   = src_q[7:0];
                state_d  = ST_W_SRCM;
            end
            ST_W_SRCM: begin
                auxdaddr = REG_SRCM;
                auxdin   = src_q[15:8];
                state_d  = ST_W_DSTL;
            end
            ST_W_DSTL: begin
                auxdaddr = REG_DSTL;
                auxdin   = dst_q[7:0];
                state_d  = ST_W_DSTM;
            end
            ST_W_DSTM: begin
                auxdaddr = REG_DSTM;
                auxdin   = dst_q[15:8];
                state_d  = ST_W_NUM;
            end
            ST_W_NUM: begin
                auxdaddr = REG_NUM;
                auxdin   = nblk_q;
                state_d  = ST_W_START;
            end
            ST_W_START: begin
                auxdaddr = REG_START;
                auxdin   = START_MAGIC;
                timer_en = 1'b1;
                state_d  = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                timer_en = 1'b1;
                if (irq) begin
                    done_cycles_d = timer_count;
                    done_bytes_d  = xfer_bytes(nblk_q, G);
                    state_d       = ST_ACK;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // A timed-out command is still acked so the DMA is released, but never reported done.
                ack     = 1'b1;
                done    = ~err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done_bytes  = done_bytes_q;
    assign done_cycles = done_cycles_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_dma_cmd_issuer.sv
// tb/tb_dma_cmd_issuer.sv - randomized bench: issuer + behavioural DMA and byte memory
`timescale 1ns/1ps
module tb_dma_cmd_issuer;

    localparam logic [2:0]  TB_G       = 3'd2;
    localparam logic [15:0] TB_TIMEOUT = 16'd300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_src = 16'h0000;
    logic [15:0] cmd_dst = 16'h0000;
    logic [7:0]  cmd_nblk = 8'h00;
    logic [15:0] auxdaddr;
    logic [7:0]  auxdin;
    logic        irq;
    logic        ack;
    logic        done;
    logic [15:0] done_bytes;
    logic [15:0] done_cycles;
    logic        timeout_err;

    always #5 clk = ~clk;

    dma_cmd_issuer #(.G(TB_G), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_nblk    (cmd_nblk),
        .auxdaddr    (auxdaddr),
        .auxdin      (auxdin),
        .irq         (irq),
        .ack         (ack),
        .done        (done),
        .done_bytes  (done_bytes),
        .done_cycles (done_cycles),
        .timeout_err (timeout_err)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_test = "reset";

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_test, tag, obs, exp);
    endtask

    // Behavioural DMA: latches register writes, copies on START, raises irq lat_cfg cycles later.
    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    logic [7:0] mem [0:65535];
    logic [7:0] dreg [0:7];
    wr_t        wlog[$];
    int         cyc = 0;
    int         lat_cfg = 13;
    int         dly = 0;
    bit         busy = 1'b0;
    logic       dma_irq = 1'b0;
    bit         force_hi = 1'b0;
    bit         force_lo = 1'b0;
    int         ack_cnt = 0;
    int         done_cnt = 0;
    int         ack_cyc = 0;

    assign irq = (dma_irq & ~force_lo) | force_hi;

    always @(negedge clk) begin
        logic [15:0] s, d, n;
        cyc++;
        if (ack) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (done) done_cnt++;
        if (rst) begin
            dma_irq = 1'b0;
            busy    = 1'b0;
        end else begin
            if (ack) begin
                dma_irq = 1'b0;
                busy    = 1'b0;
            end else if (busy && !dma_irq) begin
                dly--;
                if (dly <= 0) dma_irq = 1'b1;
            end
            if (auxdaddr != 16'h0000 || auxdin != 8'h00) begin
                wlog.push_back('{auxdaddr, auxdin, cyc});
                if (auxdaddr >= 16'h0101 && auxdaddr <= 16'h0105) begin
                    dreg[auxdaddr[2:0]] = auxdin;
                end else if (auxdaddr == 16'h0100 && auxdin == 8'hFF) begin
                    s = {dreg[2], dreg[1]};
                    d = {dreg[4], dreg[3]};
                    n = ({8'h00, dreg[5]} + 16'd1) << TB_G;
                    for (int i = 0; i < int'(n); i++) mem[d + 16'(i)] = mem[s + 16'(i)];
                    busy = 1'b1;
                    dly  = lat_cfg;
                end
            end
        end
    end

    task automatic check_reset_values();
        check_eq("rst_ack", ack, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_addr", auxdaddr, 0);
        check_eq("rst_din", auxdin, 0);
        check_eq("rst_bytes", done_bytes, 0);
        check_eq("rst_cycles", done_cycles, 0);
        check_eq("rst_err", timeout_err, 0);
    endtask

    // Issue one command and check the whole transaction against the spec-level expectations.
    task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] nblk,
                           input int lat, input bit expect_to, input bit hold_garbage);
        int         nbytes;
        int         acks0, dones0, bad, k;
        bit         seen;
        logic [7:0]  exp_data[$];
        logic [15:0] exp_a[6];
        logic [7:0]  exp_d[6];
        logic [15:0] a;

        nbytes = (int'(nblk) + 1) << TB_G;
        exp_a = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0100};
        exp_d = '{src[7:0], src[15:8], dst[7:0], dst[15:8], nblk, 8'hFF};
        for (int i = 0; i < nbytes; i++) begin
            a = src + 16'(i);
            mem[a] = 8'($urandom);
            exp_data.push_back(mem[a]);
        end
        lat_cfg = lat;
        wlog.delete();
        acks0  = ack_cnt;
        dones0 = done_cnt;

        cmd_valid = 1'b1;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_nblk  = nblk;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("accept_ready", cmd_ready, 1);
        @(negedge clk);
        if (hold_garbage) begin
            cmd_src  = ~src;
            cmd_dst  = ~dst;
            cmd_nblk = ~nblk;
        end else begin
            cmd_valid = 1'b0;
        end

        seen = 1'b0;
        for (int i = 0; i < lat + int'(TB_TIMEOUT) + 40; i++) begin
            if (ack) begin
                seen = 1'b1;
                cmd_valid = 1'b0;
                if (expect_to) begin
                    check_eq("to_err", timeout_err, 1);
                    check_eq("to_done", done, 0);
                end else begin
                    check_eq("done", done, 1);
                    check_eq("done_bytes", done_bytes, nbytes);
                    check_eq("done_cycles", done_cycles, lat);
                    check_eq("err", timeout_err, 0);
                end
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check_eq("ack_seen", seen, 1);
        repeat (3) @(negedge clk);

        check_eq("ack_count", ack_cnt - acks0, 1);
        check_eq("done_count", done_cnt - dones0, expect_to ? 0 : 1);
        check_eq("n_writes", wlog.size(), 6);
        if (wlog.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check_eq("wr_addr", wlog[i].a, exp_a[i]);
                check_eq("wr_data", wlog[i].d, exp_d[i]);
                check_eq("wr_cycle", wlog[i].c - wlog[0].c, i);
            end
            check_eq("ack_latency", ack_cyc - wlog[5].c, (expect_to ? int'(TB_TIMEOUT) : lat) + 1);
        end
        if (!expect_to) begin
            bad = 0;
            for (int i = 0; i < nbytes; i++) begin
                if (mem[dst + 16'(i)] !== exp_data[i]) bad++;
            end
            check_eq("mem_copy", bad, 0);
        end
        check_eq("idle_ready", cmd_ready, 1);
    endtask

    initial begin
        int acks0, dones0;
        bit ready_ok;
        logic [7:0] nb;

        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", cmd_ready, 1);

        cur_test = "basic";
        run_cmd(16'h2000, 16'h3000, 8'h00, 13, 1'b0, 1'b0);

        cur_test = "held_valid";
        run_cmd(16'h2100, 16'h3100, 8'h03, 25, 1'b0, 1'b1);
        run_cmd(16'h2200, 16'h3200, 8'h01, 7, 1'b0, 1'b0);

        cur_test = "max_nblk";
        run_cmd(16'h1000, 16'h9000, 8'hFF, 40, 1'b0, 1'b0);

        cur_test = "random";
        for (int r = 0; r < 8; r++) begin
            nb = 8'($urandom_range(0, 63));
            run_cmd(16'($urandom_range(0, 16'h7000)), 16'h8000 + 16'($urandom_range(0, 16'h7000)),
                    nb, $urandom_range(1, 200), 1'b0, 1'b0);
        end

        cur_test = "rst_mid";
        acks0 = ack_cnt;
        lat_cfg = 100;
        cmd_valid = 1'b1;
        cmd_src = 16'h4000;
        cmd_dst = 16'h5000;
        cmd_nblk = 8'h02;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", cmd_ready, 1);
        repeat (120) @(negedge clk);
        check_eq("no_ack_after_rst", ack_cnt - acks0, 0);
        run_cmd(16'h4000, 16'h5000, 8'h02, 17, 1'b0, 1'b0);

`ifdef DMA_ISSUER_TIMEOUT_EN
        cur_test = "timeout";
        force_lo = 1'b1;
        run_cmd(16'h6000, 16'h7000, 8'h00, 50, 1'b1, 1'b0);
        force_lo = 1'b0;
        check_eq("err_sticky", timeout_err, 1);
        run_cmd(16'h6100, 16'h7100, 8'h00, 9, 1'b0, 1'b0);
`endif

        cur_test = "stray_irq";
        acks0 = ack_cnt;
        dones0 = done_cnt;
        ready_ok = 1'b1;
        force_hi = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!cmd_ready) ready_ok = 1'b0;
        end
        force_hi = 1'b0;
        @(negedge clk);
        check_eq("stray_ack", ack_cnt - acks0, 0);
        check_eq("stray_done", done_cnt - dones0, 0);
        check_eq("stray_ready", ready_ok, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
